// File: rtl/stream_serializer_pkg.sv
// Shared types and sizing helpers for stream_serializer.
package stream_serializer_pkg;

  typedef enum logic {IDLE, SEND} ser_state_t;

  function automatic int ratio(input int in_width, input int out_width);
    return in_width / out_width;
  endfunction

  function automatic int cnt_width(input int r);
    int c;
    c = $clog2(r);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/stream_serializer.sv
// Splits each InWidth-bit input word into Ratio OutWidth-bit beats, flagging the last one.
// Build option: STREAM_SERIALIZER_MSB_FIRST_EN emits the most significant slice first.
module stream_serializer
  import stream_serializer_pkg::*;
#(
  parameter int InWidth  = 32,
  parameter int OutWidth = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                in_valid,
  input  logic [InWidth-1:0]  in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [OutWidth-1:0] out_data,
  output logic                out_last,
  input  logic                out_ready
);

  localparam int Ratio    = ratio(InWidth, OutWidth);
  localparam int CntWidth = cnt_width(Ratio);
  localparam logic [CntWidth-1:0] LastBeat = CntWidth'(Ratio - 1);

  if ((InWidth % OutWidth) != 0 || Ratio < 2) begin : g_param_check
    $error("stream_serializer: InWidth must be a multiple of OutWidth with Ratio >= 2");
  end

  ser_state_t            state_reg;
  logic [InWidth-1:0]    hold_reg;
  logic [CntWidth-1:0]   beat_reg;
  logic [OutWidth-1:0]   beat_slice [Ratio];

  // beat_slice[k] is the k-th beat on the wire, so the beat order is fixed here.
  for (genvar gi = 0; gi < Ratio; gi++) begin : g_slice
`ifdef STREAM_SERIALIZER_MSB_FIRST_EN
    assign beat_slice[gi] = hold_reg[(Ratio-1-gi)*OutWidth +: OutWidth];
`else
    assign beat_slice[gi] = hold_reg[gi*OutWidth +: OutWidth];
`endif
  end

  assign out_valid = (state_reg == SEND);
  assign out_last  = out_valid && (beat_reg == LastBeat);
  assign out_data  = beat_slice[beat_reg];
  // Accepting on the last-beat handshake gives gap-free back-to-back words.
  assign in_ready  = (state_reg == IDLE) || (out_last && out_ready);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      hold_reg  <= '0;
      beat_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            hold_reg  <= in_data;
            beat_reg  <= '0;
            state_reg <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (beat_reg != LastBeat) begin
              beat_reg <= beat_reg + 1'b1;
            end else if (in_valid) begin
              hold_reg <= in_data;
              beat_reg <= '0;
            end else begin
              beat_reg  <= '0;
              state_reg <= IDLE;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          beat_reg  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_serializer.sv
// Self-checking bench for stream_serializer: vector table, corner sequences, random vs queue model.
module tb_stream_serializer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, out_ready, in_ready, out_valid, out_last;
  logic [31:0] in_data;
  logic [7:0]  out_data;

  logic        in_valid24, out_ready24, in_ready24, out_valid24, out_last24;
  logic [23:0] in_data24;
  logic [7:0]  out_data24;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stream_serializer #(.InWidth(32), .OutWidth(8)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready)
  );

  stream_serializer #(.InWidth(24), .OutWidth(8)) dut24 (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid24), .in_data(in_data24), .in_ready(in_ready24),
    .out_valid(out_valid24), .out_data(out_data24), .out_last(out_last24),
    .out_ready(out_ready24)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // k-th beat of a word of nbeats bytes, in wire order
  function automatic logic [7:0] nth_beat(input logic [31:0] word, input int nbeats, input int k);
`ifdef STREAM_SERIALIZER_MSB_FIRST_EN
    return word[8*(nbeats-1-k) +: 8];
`else
    return word[8*k +: 8];
`endif
  endfunction

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        ov;
    logic [7:0]  od;
    logic        ol;
    logic        ir;
  } vec_t;

  vec_t tbl [26];
  logic [7:0] mq [$];
  logic [31:0] exp24 [2];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // single word, back-to-back pair, then backpressure mid-word and on the last beat
    tbl[0]  = '{1'b1, 32'hA1B2C3D4, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hD4, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hC3, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hB2, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hA1, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 32'h11223344, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 32'h55667788, 1'b1, 1'b1, 8'h44, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 32'h55667788, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 32'h55667788, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 32'h55667788, 1'b1, 1'b1, 8'h11, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h88, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h77, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h66, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h55, 1'b1, 1'b1};
    tbl[15] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hEF, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hBE, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 32'h12345678, 1'b0, 1'b1, 8'hAD, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 32'h12345678, 1'b0, 1'b1, 8'hAD, 1'b0, 1'b0};
    tbl[20] = '{1'b1, 32'h12345678, 1'b0, 1'b1, 8'hAD, 1'b0, 1'b0};
    tbl[21] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hAD, 1'b0, 1'b0};
    tbl[22] = '{1'b1, 32'h12345678, 1'b0, 1'b1, 8'hDE, 1'b1, 1'b0};
    tbl[23] = '{1'b1, 32'h12345678, 1'b0, 1'b1, 8'hDE, 1'b1, 1'b0};
    tbl[24] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hDE, 1'b1, 1'b1};
    tbl[25] = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h00, 1'b0, 1'b1};

    rstn = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    in_valid24 = 1'b0; in_data24 = '0; out_ready24 = 1'b1;

    // reset
    repeat (2) @(negedge clk);
    #1;
    chk("reset_in_ready_during", {31'b0, in_ready}, 32'd1);
    rstn = 1'b1;
    @(negedge clk); #1;
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_out_last",  {31'b0, out_last},  32'd0);
    chk("reset_out_data",  {24'b0, out_data},  32'd0);
    chk("reset_in_ready",  {31'b0, in_ready},  32'd1);

    // vector table
    @(negedge clk);
    for (int i = 0; i < 26; i++) begin
      in_valid = tbl[i].iv; in_data = tbl[i].id; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].ov});
      chk($sformatf("vec%0d_in_ready", i),  {31'b0, in_ready},  {31'b0, tbl[i].ir});
      if (tbl[i].ov) begin
        chk($sformatf("vec%0d_out_data", i), {24'b0, out_data}, {24'b0, tbl[i].od});
        chk($sformatf("vec%0d_out_last", i), {31'b0, out_last}, {31'b0, tbl[i].ol});
      end
      @(negedge clk);
    end

    // reset in the middle of a word
    in_valid = 1'b1; in_data = 32'h0BADF00D; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0; #1;
    chk("midrst_beat0", {24'b0, out_data}, 32'h0D);
    @(negedge clk); #1;
    chk("midrst_beat1", {24'b0, out_data}, 32'hF0);
    rstn = 1'b0; #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_out_last",  {31'b0, out_last},  32'd0);
    chk("midrst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("midrst_out_data",  {24'b0, out_data},  32'd0);
    @(negedge clk);
    rstn = 1'b1; in_valid = 1'b1; in_data = 32'h01020304;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); in_valid = 1'b0; #1;
      chk($sformatf("postrst_beat%0d_data", k), {24'b0, out_data}, {24'b0, nth_beat(32'h01020304, 4, k)});
      chk($sformatf("postrst_beat%0d_last", k), {31'b0, out_last}, (k == 3) ? 32'd1 : 32'd0);
    end
    @(negedge clk); #1;
    chk("postrst_idle", {31'b0, out_valid}, 32'd0);

    // 24/8 instance: ratio 3, counter must wrap at 2, back-to-back words
    exp24[0] = 32'h00AABBCC; exp24[1] = 32'h00123456;
    in_valid24 = 1'b1; in_data24 = 24'hAABBCC; out_ready24 = 1'b1; #1;
    chk("w24_idle_ready", {31'b0, in_ready24}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) in_data24 = 24'h123456;
      if (k == 3) in_valid24 = 1'b0;
      #1;
      chk($sformatf("w24_beat%0d_valid", k), {31'b0, out_valid24}, 32'd1);
      chk($sformatf("w24_beat%0d_data", k), {24'b0, out_data24}, {24'b0, nth_beat(exp24[k/3], 3, k%3)});
      chk($sformatf("w24_beat%0d_last", k), {31'b0, out_last24}, (k % 3 == 2) ? 32'd1 : 32'd0);
      chk($sformatf("w24_beat%0d_ready", k), {31'b0, in_ready24}, (k % 3 == 2) ? 32'd1 : 32'd0);
    end
    @(negedge clk); #1;
    chk("w24_idle_after", {31'b0, out_valid24}, 32'd0);

    // random traffic against a queue of pending beats
    mq.delete();
    for (int c = 0; c < 400; c++) begin
      logic exp_ov, exp_ir;
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      #1;
      exp_ov = (mq.size() > 0);
      exp_ir = (mq.size() == 0) || (mq.size() == 1 && out_ready);
      chk($sformatf("rnd%0d_out_valid", c), {31'b0, out_valid}, {31'b0, exp_ov});
      chk($sformatf("rnd%0d_in_ready", c),  {31'b0, in_ready},  {31'b0, exp_ir});
      if (exp_ov) begin
        chk($sformatf("rnd%0d_out_data", c), {24'b0, out_data}, {24'b0, mq[0]});
        chk($sformatf("rnd%0d_out_last", c), {31'b0, out_last}, (mq.size() == 1) ? 32'd1 : 32'd0);
      end
      if (exp_ov && out_ready) void'(mq.pop_front());
      if (exp_ir && in_valid)
        for (int k = 0; k < 4; k++) mq.push_back(nth_beat(in_data, 4, k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
